// File: rtl/dmem_responder_if.sv
// Load/store port between the stall-aware MIPS datapath and its data-memory responder.
// The datapath is the master; the responder is the slave.
interface dmem_responder_if;
    logic [31:0] dir;
    logic        memreads;
    logic        memwrites;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output dir, memreads, memwrites, datain,
        input  dataout, ready, err, busy
    );

    modport slave (
        input  dir, memreads, memwrites, datain,
        output dataout, ready, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word-addressed RAM with programmable wait
// states, a one-cycle ready pulse, and error flagging for illegal accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      inclk,
    input  logic      rst_n,
    dmem_responder_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for memreads/memwrites; request accepted on the edge
    // WAIT    | counting down wait states with the latched request
    // RESP    | ready pulse (err qualified); always back to IDLE next edge

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic [31:0]     datain_q;
    logic            rd_q, wr_q, err_q;
    logic [31:0]     dataout_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            req_err;
    logic            accept;
    logic            access;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_din;
    logic            acc_rd, acc_wr, acc_err;

    assign req     = bus.memreads | bus.memwrites;
    assign req_err = (bus.dir[1:0] != 2'b00)
                   || ((bus.dir >> (AW + 2)) != 32'd0)
                   || (bus.memreads && bus.memwrites);

    // With no wait states the access happens on the accepting edge, so it must
    // use the live request rather than the (not yet loaded) latched copy.
    assign acc_idx = (state_q == ST_IDLE) ? bus.dir[AW+1:2] : idx_q;
    assign acc_din = (state_q == ST_IDLE) ? bus.datain      : datain_q;
    assign acc_rd  = (state_q == ST_IDLE) ? bus.memreads    : rd_q;
    assign acc_wr  = (state_q == ST_IDLE) ? bus.memwrites   : wr_q;
    assign acc_err = (state_q == ST_IDLE) ? req_err         : err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (NO_WAIT) begin
                        state_d = ST_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            datain_q  <= 32'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            dataout_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q    <= bus.dir[AW+1:2];
                datain_q <= bus.datain;
                rd_q     <= bus.memreads;
                wr_q     <= bus.memwrites;
                err_q    <= req_err;
            end
            // Only a pure read updates dataout; writes and dual-strobe errors leave it alone.
            if (access && acc_rd && !acc_wr) begin
                dataout_q <= acc_err ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // RAM is deliberately not reset; the rst_n gate drops a same-edge access during reset.
    always_ff @(posedge inclk) begin
        if (rst_n && access && acc_wr && !acc_rd && !acc_err) begin
            mem[acc_idx] <= acc_din;
        end
    end

    assign bus.dataout = dataout_q;
    assign bus.ready   = (state_q == ST_RESP);
    assign bus.err     = (state_q == ST_RESP) && err_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 15 wait states) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_responder;
    localparam int NDUT  = 3;
    localparam int DEPTH = 64;

    logic inclk = 1'b0;
    logic rst_n = 1'b1;
    always #5 inclk = ~inclk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] in_dir [NDUT];
    logic        in_rd  [NDUT];
    logic        in_wr  [NDUT];
    logic [31:0] in_din [NDUT];
    logic [31:0] o_dout [NDUT];
    logic        o_ready[NDUT];
    logic        o_err  [NDUT];
    logic        o_busy [NDUT];

    dmem_responder_if bus0();
    dmem_responder_if bus1();
    dmem_responder_if bus2();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2))  u_dut0 (.inclk(inclk), .rst_n(rst_n), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0))  u_dut1 (.inclk(inclk), .rst_n(rst_n), .bus(bus1));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(15)) u_dut2 (.inclk(inclk), .rst_n(rst_n), .bus(bus2));

    assign bus0.dir = in_dir[0]; assign bus0.memreads = in_rd[0]; assign bus0.memwrites = in_wr[0]; assign bus0.datain = in_din[0];
    assign bus1.dir = in_dir[1]; assign bus1.memreads = in_rd[1]; assign bus1.memwrites = in_wr[1]; assign bus1.datain = in_din[1];
    assign bus2.dir = in_dir[2]; assign bus2.memreads = in_rd[2]; assign bus2.memwrites = in_wr[2]; assign bus2.datain = in_din[2];
    assign o_dout[0] = bus0.dataout; assign o_ready[0] = bus0.ready; assign o_err[0] = bus0.err; assign o_busy[0] = bus0.busy;
    assign o_dout[1] = bus1.dataout; assign o_ready[1] = bus1.ready; assign o_err[1] = bus1.err; assign o_busy[1] = bus1.busy;
    assign o_dout[2] = bus2.dataout; assign o_ready[2] = bus2.ready; assign o_err[2] = bus2.err; assign o_busy[2] = bus2.busy;

    function automatic int wait_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request is accepted when nothing is in flight,
    // responds WAIT edges later, and the slot frees one edge after the response.
    logic [31:0] m_mem   [NDUT][DEPTH];
    bit          m_known [NDUT][DEPTH];
    bit          m_act   [NDUT];
    int          m_edge  [NDUT];
    int          m_resp  [NDUT];
    logic [31:0] m_dir   [NDUT];
    logic [31:0] m_din   [NDUT];
    bit          m_rd    [NDUT];
    bit          m_wr    [NDUT];
    logic [31:0] e_dout  [NDUT];
    bit          e_known [NDUT];
    bit          e_ready [NDUT];
    bit          e_err   [NDUT];
    bit          e_busy  [NDUT];

    task automatic model_access(input int k);
        bit err;
        int idx;
        err = (m_dir[k] % 4 != 0) || (m_dir[k] >= 4 * DEPTH) || (m_rd[k] && m_wr[k]);
        idx = int'(m_dir[k] / 4);
        e_err[k] = err;
        if (m_rd[k] && !m_wr[k]) begin
            if (err) begin
                e_dout[k]  = 32'd0;
                e_known[k] = 1'b1;
            end else begin
                e_dout[k]  = m_mem[k][idx];
                e_known[k] = m_known[k][idx];
            end
        end else if (m_wr[k] && !m_rd[k] && !err) begin
            m_mem[k][idx]   = m_din[k];
            m_known[k][idx] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge inclk or negedge rst_n);
            for (int k = 0; k < NDUT; k++) begin
                if (!rst_n) begin
                    m_act[k]   = 1'b0;
                    e_ready[k] = 1'b0;
                    e_err[k]   = 1'b0;
                    e_busy[k]  = 1'b0;
                    e_dout[k]  = 32'd0;
                    e_known[k] = 1'b1;
                end else begin
                    m_edge[k]++;
                    if (!m_act[k]) begin
                        if (in_rd[k] || in_wr[k]) begin
                            m_act[k]  = 1'b1;
                            m_resp[k] = m_edge[k] + wait_of(k);
                            m_dir[k]  = in_dir[k];
                            m_din[k]  = in_din[k];
                            m_rd[k]   = in_rd[k];
                            m_wr[k]   = in_wr[k];
                        end
                    end else if (m_edge[k] == m_resp[k] + 1) begin
                        m_act[k] = 1'b0;
                    end
                    e_busy[k]  = m_act[k];
                    e_ready[k] = m_act[k] && (m_edge[k] == m_resp[k]);
                    if (e_ready[k]) model_access(k);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge inclk);
            if (chk_en) begin
                for (int k = 0; k < NDUT; k++) begin
                    check("ready", k, 32'(o_ready[k]), 32'(e_ready[k]));
                    check("busy", k, 32'(o_busy[k]), 32'(e_busy[k]));
                    if (e_ready[k]) check("err", k, 32'(o_err[k]), 32'(e_err[k]));
                    if (e_known[k]) check("dataout", k, o_dout[k], e_dout[k]);
                end
            end
        end
    end

    task automatic txn(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit toggle,
                       output int lat, output logic [31:0] dout, output logic err);
        @(negedge inclk);
        in_dir[k] = a;
        in_din[k] = d;
        in_rd[k]  = rd;
        in_wr[k]  = wr;
        lat  = -1;
        dout = 32'd0;
        err  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge inclk);
            in_rd[k] = 1'b0;
            in_wr[k] = 1'b0;
            if (toggle) in_dir[k] = in_dir[k] ^ 32'h3C;
            if (o_ready[k]) begin
                lat  = i;
                dout = o_dout[k];
                err  = o_err[k];
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: no ready within 40 cycles for addr %h", k, a);
        end
    endtask

    int          lat;
    logic [31:0] dout;
    logic        err;

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            in_dir[k] = 32'd0; in_din[k] = 32'd0; in_rd[k] = 1'b0; in_wr[k] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", k, 32'(o_ready[k]), 32'd0);
            check("rst_busy", k, 32'(o_busy[k]), 32'd0);
            check("rst_err", k, 32'(o_err[k]), 32'd0);
            check("rst_dout", k, o_dout[k], 32'd0);
        end
        repeat (2) @(negedge inclk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // write then read, 2 wait states
        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, dout, err);
        check("wr_lat", 0, 32'(lat), 32'd3);
        check("wr_err", 0, 32'(err), 32'd0);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, dout, err);
        check("rd_lat", 0, 32'(lat), 32'd3);
        check("rd_data", 0, dout, 32'hDEADBEEF);
        check("rd_err", 0, 32'(err), 32'd0);

        // misaligned and out of range
        txn(0, 1'b0, 1'b1, 32'h00, 32'hA5A5A5A5, 1'b0, lat, dout, err);
        txn(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, lat, dout, err);
        check("misal_err", 0, 32'(err), 32'd1);
        check("misal_dout", 0, dout, 32'd0);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, dout, err);
        txn(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, lat, dout, err);
        check("oor_err", 0, 32'(err), 32'd1);
        check("oor_dout", 0, dout, 32'd0);
        txn(0, 1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b0, lat, dout, err);
        check("oor_wr_err", 0, 32'(err), 32'd1);
        txn(0, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, lat, dout, err);
        check("oor_no_alias", 0, dout, 32'hA5A5A5A5);

        // both strobes high
        txn(0, 1'b0, 1'b1, 32'h20, 32'h1234, 1'b0, lat, dout, err);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, dout, err);
        txn(0, 1'b1, 1'b1, 32'h20, 32'h9999, 1'b0, lat, dout, err);
        check("both_err", 0, 32'(err), 32'd1);
        check("both_dout_held", 0, dout, 32'hDEADBEEF);
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, dout, err);
        check("both_no_write", 0, dout, 32'h1234);

        // reset one cycle after accepting a write
        txn(0, 1'b0, 1'b1, 32'h08, 32'h11111111, 1'b0, lat, dout, err);
        @(negedge inclk);
        in_dir[0] = 32'h08; in_din[0] = 32'hCAFEF00D; in_wr[0] = 1'b1;
        @(negedge inclk);
        in_wr[0] = 1'b0;
        check("pre_rst_busy", 0, 32'(o_busy[0]), 32'd1);
        @(posedge inclk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 0, 32'(o_ready[0]), 32'd0);
        check("mid_rst_busy", 0, 32'(o_busy[0]), 32'd0);
        check("mid_rst_err", 0, 32'(o_err[0]), 32'd0);
        check("mid_rst_dout", 0, o_dout[0], 32'd0);
        repeat (2) @(negedge inclk);
        rst_n = 1'b1;
        txn(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, lat, dout, err);
        check("rst_discard", 0, dout, 32'h11111111);

        // zero wait states, request held high
        txn(1, 1'b0, 1'b1, 32'h04, 32'h00000077, 1'b0, lat, dout, err);
        check("w0_lat", 1, 32'(lat), 32'd1);
        @(negedge inclk);
        in_dir[1] = 32'h04; in_rd[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge inclk);
            check("held_ready", 1, 32'(o_ready[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("held_busy", 1, 32'(o_busy[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("held_dout", 1, o_dout[1], 32'h77);
        end
        in_rd[1] = 1'b0;

        // fifteen wait states, address toggled during WAIT
        txn(2, 1'b0, 1'b1, 32'h0C, 32'h5555AAAA, 1'b0, lat, dout, err);
        check("w15_wr_lat", 2, 32'(lat), 32'd16);
        txn(2, 1'b0, 1'b1, 32'h30, 32'h0F0F0F0F, 1'b0, lat, dout, err);
        txn(2, 1'b1, 1'b0, 32'h0C, 32'h0, 1'b1, lat, dout, err);
        check("w15_rd_lat", 2, 32'(lat), 32'd16);
        check("w15_rd_data", 2, dout, 32'h5555AAAA);
        check("w15_rd_err", 2, 32'(err), 32'd0);

        repeat (3) @(negedge inclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
